cpu_flags_mt: RTL and testbench
===============================

# cpu_flags_mt

Per-thread flag file for the multi-threaded md5crypt CPU, generalised to any flag count and thread count. Holds the active thread's flags in a register, saves and restores them to and from per-thread storage on a thread switch, and evaluates a generic {enable, invert, index} branch condition. After reset it clears all per-thread storage with a sweep, and it can optionally push and pop flags on a per-thread stack around subroutine calls. Sits between the instruction decoder (conditions, flag updates) and the thread scheduler (load/save).

## Interface
- N_FLAGS, 4: number of flags, ≥1.
- N_THREADS, 16: number of threads, power of 2, ≥2.
- STACK_DEPTH, 4: flag-stack entries per thread, power of 2. Used only with CPU_FLAGS_STACK_EN.
- Derived: TH_W = clog2(N_THREADS); IDX_W = max(1, clog2(N_FLAGS)); COND_W = IDX_W+2.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- init_done  out  1  0 during the clear sweep, 1 in RUN.
- thread_num  in  TH_W  thread addressed by load/save/push/pop.
- load_en  in  1  flags <= stored flags of thread_num.
- save_en  in  1  stored flags of thread_num <= flags.
- flags  out  N_FLAGS  active flags.
- op_condition  in  COND_W  condition fields:
  - [COND_W-1] = enable; 0 means always true.
  - [COND_W-2] = invert.
  - [IDX_W-1:0] = flag index.
- condition_is_true  out  1  condition result.
- set_flags  in  1  masked flag update.
- iop_flag_mask  in  N_FLAGS  bits to update.
- flags_in  in  N_FLAGS  new flag values.
- push_en, pop_en  in  1  flag-stack operations; present only with the macro.
- stack_err  out  1  sticky overflow/underflow indicator; present only with the macro.

## Operation
- States: INIT and RUN.
  - RST_N low forces INIT and clears the sweep counter, flags, and stack_err.
  - In INIT, each cycle writes 0 to flags_mem[cnt] and (with the macro) to sp[cnt], then cnt++.
  - After the write at cnt = N_THREADS-1, the block enters RUN.
  - A reset in mid-sweep or mid-run restarts the full sweep.
- In INIT, load_en, save_en, set_flags, push_en and pop_en are ignored. condition_is_true is still evaluated on flags, which is 0.
- Flag register update priority, highest first:
  1. load_en
  2. pop_en (valid pop)
  3. set_flags
- set_flags updates only bits k where iop_flag_mask[k]=1.
- save_en writes the pre-edge flags.
- load_en and save_en in the same cycle: the load returns the value being saved (bypass). flags are unchanged and flags_mem[thread_num] gets flags.
- Condition evaluation:
  - enable=0: true.
  - enable=1: result = flags[idx] XOR invert.
  - idx ≥ N_FLAGS reads the flag as 0.
- Stack (with the macro only):
  - Each thread has its own stack and its own stack pointer sp (0..STACK_DEPTH).
  - push stores the pre-edge flags at stack[thread_num][sp] and increments sp.
  - pop decrements sp and loads flags from the new top.
  - Push when sp = STACK_DEPTH: dropped, stack_err <= 1.
  - Pop when sp = 0: flags unchanged by the pop, stack_err <= 1.
  - push_en and pop_en in the same cycle: no stack change, no error.
  - push together with set_flags: the pushed value is the pre-update flags.
  - stack_err clears only on reset.

## Timing
- Reset values: flags = 0, init_done = 0, stack_err = 0.
- condition_is_true is combinational from flags and op_condition (0-cycle).
- load, set_flags and pop results appear on flags 1 cycle after the sampling edge.
- A save is visible to a load of the same thread on the following cycle. In the same cycle it is visible through the bypass.
- init_done rises exactly N_THREADS rising edges after RST_N deasserts.
- Storage is distributed RAM with synchronous write and asynchronous read. It has no reset; it is cleared only by the sweep.

## Configuration
- CPU_FLAGS_STACK_EN
  - Defined: push_en, pop_en and stack_err ports exist, and the per-thread stack and sp memories are built. The sweep clears sp.
  - Undefined: those ports and memories are absent and pop is never a flag source. All other behaviour is identical.

## Structure
- Package cpu_flags_pkg holds:
  - The condition field positions (COND_EN_BIT, COND_INV_BIT, index LSB).
  - The state enum {ST_INIT, ST_RUN}.
  - clog2/width helper functions.
- Sub-module cpu_flags_stack, instantiated only under the macro:
  - Per-thread sp memory plus stack memory.
  - Inputs: thread_num, push, pop, data_in.
  - Outputs: data_out, pop_valid, err pulse.
  - The parent registers the sticky stack_err.

## Test plan
- Reset sweep: N_THREADS=16.
  - Deassert RST_N → init_done=0 for 16 cycles, then 1.
  - load_en for every thread → flags=0.
- Masked update and condition: flags=0000.
  - set_flags, mask=0101, flags_in=1111 → flags=0101.
  - op_condition {1,0,idx=2} → true.
  - op_condition {1,1,idx=2} → false.
  - op_condition {0,x,x} → true.
- Save/load and bypass:
  - Save 1010 to thread 3, save 0110 to thread 7, then load 3 → flags=1010.
  - Same-cycle load+save on thread 7 with flags=0011 → flags stay 0011 and a later load 7 gives 0011.
- Priority: load_en + set_flags in the same cycle → flags = stored value; set_flags is ignored.
- Stack (macro defined, STACK_DEPTH=4):
  - Push 0001, 0010, 0011, 0100 on thread 2; a 5th push → stack_err=1.
  - Four pops → 0100, 0011, 0010, 0001.
  - A pop on empty thread 5 → flags unchanged.
- Mid-operation reset: assert RST_N during the sweep at cnt=9 → the sweep restarts and init_done rises 16 cycles after release.

Source files
------------

// File: rtl/cpu_flags_pkg.sv
// Shared types and elaboration helpers for the per-thread flag file.
package cpu_flags_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam int COND_IDX_LSB = 0;

    function automatic int f_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int f_width(input int v);
        return (f_clog2(v) < 1) ? 1 : f_clog2(v);
    endfunction

    // Condition word is {enable, invert, index}; positions depend on the index width.
    function automatic int cond_inv_bit(input int idx_w);
        return idx_w;
    endfunction

    function automatic int cond_en_bit(input int idx_w);
        return idx_w + 1;
    endfunction

endpackage

// File: rtl/cpu_flags_stack.sv
// Per-thread flag stack: a stack-pointer memory and a stack memory, both
// distributed RAM. Only built when CPU_FLAGS_STACK_EN is defined.
module cpu_flags_stack
    import cpu_flags_pkg::*;
#(
    parameter int N_FLAGS     = 4,
    parameter int N_THREADS   = 16,
    parameter int STACK_DEPTH = 4,
    localparam int TH_W       = f_clog2(N_THREADS),
    localparam int PTR_W      = f_width(STACK_DEPTH),
    localparam int SP_W       = f_width(STACK_DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               clr,
    input  logic [TH_W-1:0]    thread_num,
    input  logic               push,
    input  logic               pop,
    input  logic [N_FLAGS-1:0] data_in,
    output logic [N_FLAGS-1:0] data_out,
    output logic               pop_valid,
    output logic               err
);

    logic [SP_W-1:0]    sp_mem  [N_THREADS];
    logic [N_FLAGS-1:0] stk_mem [N_THREADS << PTR_W];

    logic [SP_W-1:0] sp_cur;
    logic [SP_W-1:0] sp_m1;
    logic            full;
    logic            empty;
    logic            do_push;
    logic            do_pop;

    assign sp_cur = sp_mem[thread_num];
    assign sp_m1  = sp_cur - 1'b1;
    assign full   = (sp_cur == SP_W'(STACK_DEPTH));
    assign empty  = (sp_cur == '0);

    // Simultaneous push and pop cancel out: nothing moves, nothing is flagged.
    assign do_push   = push && !pop && !full;
    assign do_pop    = pop && !push && !empty;
    assign err       = (push && !pop && full) || (pop && !push && empty);
    assign pop_valid = do_pop;
    assign data_out  = stk_mem[{thread_num, sp_m1[PTR_W-1:0]}];

    always_ff @(posedge CLK) begin
        if (clr)
            sp_mem[thread_num] <= '0;
        else if (do_push)
            sp_mem[thread_num] <= sp_cur + 1'b1;
        else if (do_pop)
            sp_mem[thread_num] <= sp_m1;
    end

    always_ff @(posedge CLK) begin
        if (!clr && do_push)
            stk_mem[{thread_num, sp_cur[PTR_W-1:0]}] <= data_in;
    end

endmodule

// File: rtl/cpu_flags_mt.sv
// Per-thread flag file with save/restore, branch-condition evaluation and a
// post-reset clear sweep. Define CPU_FLAGS_STACK_EN to add the push/pop flag stack.
module cpu_flags_mt
    import cpu_flags_pkg::*;
#(
    parameter int N_FLAGS     = 4,
    parameter int N_THREADS   = 16,
    parameter int STACK_DEPTH = 4,
    localparam int TH_W       = f_clog2(N_THREADS),
    localparam int IDX_W      = f_width(N_FLAGS),
    localparam int COND_W     = IDX_W + 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    output logic               init_done,
    input  logic [TH_W-1:0]    thread_num,
    input  logic               load_en,
    input  logic               save_en,
    output logic [N_FLAGS-1:0] flags,
    input  logic [COND_W-1:0]  op_condition,
    output logic               condition_is_true,
    input  logic               set_flags,
    input  logic [N_FLAGS-1:0] iop_flag_mask,
    input  logic [N_FLAGS-1:0] flags_in
`ifdef CPU_FLAGS_STACK_EN
    ,
    input  logic               push_en,
    input  logic               pop_en,
    output logic               stack_err
`endif
);

    localparam int COND_EN  = cond_en_bit(IDX_W);
    localparam int COND_INV = cond_inv_bit(IDX_W);

    if (N_THREADS < 2 || (1 << TH_W) != N_THREADS)
        $error("N_THREADS must be a power of 2 and at least 2");
    if (STACK_DEPTH < 1 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0)
        $error("STACK_DEPTH must be a power of 2");

    state_t             state;
    logic [TH_W-1:0]    cnt;
    logic               run;
    logic [N_FLAGS-1:0] flags_mem [N_THREADS];
    logic [TH_W-1:0]    mem_addr;
    logic               pop_vld;
    logic [N_FLAGS-1:0] pop_data;

    assign run      = (state == ST_RUN);
    assign mem_addr = run ? thread_num : cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == TH_W'(N_THREADS - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    // No reset on storage: the sweep is the only thing that clears it.
    always_ff @(posedge CLK) begin
        if (!run)
            flags_mem[mem_addr] <= '0;
        else if (save_en)
            flags_mem[mem_addr] <= flags;
    end

`ifdef CPU_FLAGS_STACK_EN
    logic stk_err;

    cpu_flags_stack #(
        .N_FLAGS     (N_FLAGS),
        .N_THREADS   (N_THREADS),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK        (CLK),
        .clr        (!run),
        .thread_num (mem_addr),
        .push       (push_en && run),
        .pop        (pop_en && run),
        .data_in    (flags),
        .data_out   (pop_data),
        .pop_valid  (pop_vld),
        .err        (stk_err)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            stack_err <= 1'b0;
        else if (stk_err)
            stack_err <= 1'b1;
    end
`else
    assign pop_vld  = 1'b0;
    assign pop_data = '0;
`endif

    // A same-cycle save makes the load return the current flags, i.e. no change.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            flags <= '0;
        else if (run) begin
            if (load_en)
                flags <= save_en ? flags : flags_mem[thread_num];
            else if (pop_vld)
                flags <= pop_data;
            else if (set_flags)
                flags <= (flags & ~iop_flag_mask) | (flags_in & iop_flag_mask);
        end
    end

    logic [IDX_W-1:0] cond_idx;
    logic             cond_flag;

    assign cond_idx  = op_condition[COND_IDX_LSB +: IDX_W];
    assign cond_flag = (int'(cond_idx) < N_FLAGS) ? flags[cond_idx] : 1'b0;
    assign condition_is_true = !op_condition[COND_EN] ||
                               (cond_flag ^ op_condition[COND_INV]);

endmodule

// File: tb/tb_cpu_flags_mt.sv
// Directed bench for cpu_flags_mt (N_FLAGS=4, N_THREADS=16, STACK_DEPTH=4).
// Stack vectors run only when CPU_FLAGS_STACK_EN is defined.
module tb_cpu_flags_mt;

    logic       CLK;
    logic       RST_N;
    logic       init_done;
    logic [3:0] thread_num;
    logic       load_en;
    logic       save_en;
    logic [3:0] flags;
    logic [3:0] op_condition;
    logic       condition_is_true;
    logic       set_flags;
    logic [3:0] iop_flag_mask;
    logic [3:0] flags_in;
`ifdef CPU_FLAGS_STACK_EN
    logic       push_en;
    logic       pop_en;
    logic       stack_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cpu_flags_mt #(
        .N_FLAGS     (4),
        .N_THREADS   (16),
        .STACK_DEPTH (4)
    ) dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .init_done         (init_done),
        .thread_num        (thread_num),
        .load_en           (load_en),
        .save_en           (save_en),
        .flags             (flags),
        .op_condition      (op_condition),
        .condition_is_true (condition_is_true),
        .set_flags         (set_flags),
        .iop_flag_mask     (iop_flag_mask),
        .flags_in          (flags_in)
`ifdef CPU_FLAGS_STACK_EN
        ,
        .push_en           (push_en),
        .pop_en            (pop_en),
        .stack_err         (stack_err)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_f(input logic [3:0] mask, input logic [3:0] val);
        set_flags = 1'b1; iop_flag_mask = mask; flags_in = val;
        tick();
        set_flags = 1'b0;
    endtask

    task automatic save_t(input logic [3:0] th);
        save_en = 1'b1; thread_num = th;
        tick();
        save_en = 1'b0;
    endtask

    task automatic load_t(input logic [3:0] th);
        load_en = 1'b1; thread_num = th;
        tick();
        load_en = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done && n < 100) begin
            tick();
            n++;
        end
        check(tag, n, 16);
    endtask

`ifdef CPU_FLAGS_STACK_EN
    task automatic push_t(input logic [3:0] th);
        push_en = 1'b1; thread_num = th;
        tick();
        push_en = 1'b0;
    endtask

    task automatic pop_t(input logic [3:0] th);
        pop_en = 1'b1; thread_num = th;
        tick();
        pop_en = 1'b0;
    endtask
`endif

    initial begin
        RST_N = 1'b0; thread_num = '0; load_en = 1'b0; save_en = 1'b0;
        op_condition = '0; set_flags = 1'b0; iop_flag_mask = '0; flags_in = '0;
`ifdef CPU_FLAGS_STACK_EN
        push_en = 1'b0; pop_en = 1'b0;
`endif
        tick();
        tick();
        check("rst_flags", flags, 0);
        check("rst_init_done", init_done, 0);
`ifdef CPU_FLAGS_STACK_EN
        check("rst_stack_err", stack_err, 0);
`endif

        // Sweep with set_flags held high; it must be ignored until RUN.
        RST_N = 1'b1;
        set_flags = 1'b1; iop_flag_mask = 4'b1111; flags_in = 4'b1111;
        op_condition = 4'b1100;
        #1;
        check("init_cond_inv", condition_is_true, 1);
        wait_init("init_cycles");
        set_flags = 1'b0;
        check("init_ignores_set", flags, 0);

        set_f(4'b1111, 4'b1111);
        check("set_all", flags, 4'b1111);
        for (int t = 0; t < 16; t++) begin
            load_en = 1'b1; thread_num = 4'(t);
            tick();
            if (t == 0 || t == 15)
                check($sformatf("load_clear_t%0d", t), flags, 0);
        end
        load_en = 1'b0;

        set_f(4'b0101, 4'b1111);
        check("masked_set", flags, 4'b0101);
        op_condition = 4'b1010; #1;
        check("cond_idx2", condition_is_true, 1);
        op_condition = 4'b1110; #1;
        check("cond_idx2_inv", condition_is_true, 0);
        op_condition = 4'b0111; #1;
        check("cond_disabled", condition_is_true, 1);
        op_condition = 4'b1001; #1;
        check("cond_idx1", condition_is_true, 0);

        set_f(4'b1111, 4'b1010);
        save_t(4'd3);
        set_f(4'b1111, 4'b0110);
        save_t(4'd7);
        load_t(4'd3);
        check("load_t3", flags, 4'b1010);
        load_t(4'd7);
        check("load_t7", flags, 4'b0110);

        set_f(4'b1111, 4'b0011);
        load_en = 1'b1; save_en = 1'b1; thread_num = 4'd7;
        tick();
        load_en = 1'b0; save_en = 1'b0;
        check("bypass_flags", flags, 4'b0011);
        set_f(4'b1111, 4'b1111);
        load_t(4'd7);
        check("bypass_stored", flags, 4'b0011);

        load_en = 1'b1; set_flags = 1'b1; iop_flag_mask = 4'b1111; flags_in = 4'b0000;
        thread_num = 4'd3;
        tick();
        load_en = 1'b0; set_flags = 1'b0;
        check("prio_load_over_set", flags, 4'b1010);

`ifdef CPU_FLAGS_STACK_EN
        set_f(4'b1111, 4'b0001); push_t(4'd2);
        set_f(4'b1111, 4'b0010); push_t(4'd2);
        set_f(4'b1111, 4'b0011); push_t(4'd2);
        // Push with a simultaneous update stores the pre-update value.
        set_f(4'b1111, 4'b0100);
        push_en = 1'b1; set_flags = 1'b1; flags_in = 4'b1000; thread_num = 4'd2;
        tick();
        push_en = 1'b0; set_flags = 1'b0;
        check("push_set_flags", flags, 4'b1000);
        check("no_err_at_full", stack_err, 0);
        push_t(4'd2);
        check("overflow_err", stack_err, 1);
        set_f(4'b1111, 4'b1111);
        pop_t(4'd2); check("pop1", flags, 4'b0100);
        pop_t(4'd2); check("pop2", flags, 4'b0011);
        pop_t(4'd2); check("pop3", flags, 4'b0010);
        pop_t(4'd2); check("pop4", flags, 4'b0001);
        pop_t(4'd5); check("pop_empty", flags, 4'b0001);
        check("err_sticky", stack_err, 1);
`endif

        // Mid-sweep reset restarts the full sweep.
        set_f(4'b1111, 4'b1001);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("mid_sweep_busy", init_done, 0);
        RST_N = 1'b0; #1;
        check("mid_rst_flags", flags, 0);
`ifdef CPU_FLAGS_STACK_EN
        check("mid_rst_err", stack_err, 0);
`endif
        tick();
        RST_N = 1'b1;
        wait_init("restart_cycles");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
